// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with a per-register
// pending-write scoreboard.
//  - NUM_REGS = 2**ADDR_W registers of DATA_W bits. Register 0 always reads
//    zero and ignores writes.
//  - NUM_RD combinational read ports, each reporting whether the addressed
//    register still has a writeback outstanding.
//  - Each register r != 0 has a CNT_W-bit count of in-flight producers.
//    Decode increments it on issue and writeback decrements it. A saturated
//    counter back-pressures issue_ready.
//  - flush discards every reservation. Data writes still commit.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a same-cycle
// writeback is forwarded to matching read ports.
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt  [NUM_REGS];
    logic              wr_valid;
    logic              issue_fire;

    // A write to register 0 is architecturally a no-op.
    always_comb begin
        wr_valid = wr_en && (wr_addr != '0);
    end

    // Refuse a reservation only when the counter is saturated and no
    // writeback to the same register retires one producer this cycle.
    always_comb begin
        issue_ready = 1'b1;
        if ((issue_addr != '0) && (cnt[issue_addr] == CNT_MAX) &&
            !(wr_en && (wr_addr == issue_addr))) begin
            issue_ready = 1'b0;
        end
        issue_fire = issue_valid && issue_ready;
    end

    // Data storage. Register 0 is only touched by reset, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_valid) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Pending counters.
    // An accepted issue and a writeback to the same register cancel, even
    // when the counter is zero. A lone writeback never underflows.
    // flush and rst both clear the counters and take priority over any
    // same-cycle issue or writeback effect.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (issue_fire && (issue_addr == ADDR_W'(r)) &&
                    !(wr_en && (wr_addr == ADDR_W'(r)))) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (wr_en && (wr_addr == ADDR_W'(r)) &&
                             !(issue_fire && (issue_addr == ADDR_W'(r))) &&
                             (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Busy flags come straight from the registered counters.
    always_comb begin
        busy_vec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    // Read ports: stored value and registered busy flag.
    // With bypass enabled, a matching writeback is forwarded. The port also
    // reports not-busy when that writeback retires the last producer.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy[i] = busy_vec[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr)) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
                if (cnt[wr_addr] <= CNT_ONE) begin
                    rd_busy[i] = 1'b0;
                end
            end
`else
            // Without bypass, a same-cycle writeback is visible next cycle.
`endif
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default parameters).
// A directed vector table, hand sequences for bypass and reset, then a
// randomized run against a reference model.
module tb_regfile_scoreboard;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_RD   = 2;
    localparam int CNT_W    = 2;
    localparam int NUM_REGS = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     issue_ready;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy_vec;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .issue_ready(issue_ready),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents and producer counts as plain ints.
    logic [DATA_W-1:0] m_reg [NUM_REGS];
    int                m_cnt [NUM_REGS];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd, input logic iv, input logic [3:0] ia,
                         input logic fl, input logic [3:0] a0, input logic [3:0] a1);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        issue_valid = iv; issue_addr = ia; flush = fl;
        rd_addr = {a1, a0};
    endtask

    function automatic bit model_ready();
        return !((issue_addr != 0) && (m_cnt[issue_addr] == CNT_MAX) &&
                 !(wr_en && (wr_addr == issue_addr)));
    endfunction

    function automatic bit byp_hit(input logic [3:0] a);
        return BYP && wr_en && (wr_addr != 0) && (a == wr_addr);
    endfunction

    function automatic logic [15:0] model_rd(input logic [3:0] a);
        return byp_hit(a) ? wr_data : m_reg[a];
    endfunction

    function automatic logic model_rbusy(input logic [3:0] a);
        if (byp_hit(a) && (m_cnt[a] <= 1)) return 1'b0;
        return m_cnt[a] != 0;
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        for (int r = 0; r < NUM_REGS; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    // Advance one clock edge, updating the model from the inputs in effect.
    task automatic tick();
        bit rdy;
        rdy = model_ready();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_reg[r] = '0;
                m_cnt[r] = 0;
            end
        end else begin
            if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
            if (flush) begin
                for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
            end else begin
                for (int r = 1; r < NUM_REGS; r++) begin
                    bit inc, w;
                    inc = issue_valid && rdy && (issue_addr == r);
                    w   = wr_en && (wr_addr == r);
                    if (inc && !w) m_cnt[r] = m_cnt[r] + 1;
                    else if (w && !inc && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rd0"},   rd_data[15:0],  model_rd(rd_addr[3:0]));
        chk({tag, ".rd1"},   rd_data[31:16], model_rd(rd_addr[7:4]));
        chk({tag, ".rbusy"}, rd_busy, {model_rbusy(rd_addr[7:4]), model_rbusy(rd_addr[3:0])});
        chk({tag, ".ready"}, issue_ready, model_ready());
        chk({tag, ".busy"},  busy_vec, model_busy());
    endtask

    typedef struct {
        logic        r, we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        iv;
        logic [3:0]  ia;
        logic        fl;
        logic [3:0]  a0, a1;
        bit          do_chk;
        logic [15:0] e0, e1;
        logic [1:0]  erb;
        logic        erdy;
        logic [15:0] ebusy;
    } vec_t;

    vec_t tbl [15];

    initial begin
        for (int r = 0; r < NUM_REGS; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);

        // r we wa wd iv ia fl a0 a1 | chk e0 e1 erb erdy ebusy
        tbl[0]  = '{1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0,  4'd0,  1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd1,  4'd2,  1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd15, 4'd14, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd1,  4'd2,  1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0,  4'd5,  1'b1, 16'h0000, 16'hBEEF, 2'b00, 1'b1, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0,  4'd5,  1'b1, 16'h0000, 16'hBEEF, 2'b00, 1'b1, 16'h0000};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd3,  4'd3,  1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000};
        tbl[7]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd3,  4'd3,  1'b1, 16'h0000, 16'h0000, 2'b11, 1'b1, 16'h0008};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd3,  4'd3,  1'b1, 16'h0000, 16'h0000, 2'b11, 1'b1, 16'h0008};
        tbl[9]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd3,  4'd3,  1'b1, 16'h0000, 16'h0000, 2'b11, 1'b0, 16'h0008};
        tbl[10] = '{1'b0, 1'b1, 4'd3, 16'h0033, 1'b1, 4'd3, 1'b0, 4'd1,  4'd2,  1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0008};
        tbl[11] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd3,  4'd5,  1'b1, 16'h0033, 16'hBEEF, 2'b01, 1'b0, 16'h0008};
        tbl[12] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0, 4'd1,  4'd2,  1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0008};
        tbl[13] = '{1'b0, 1'b1, 4'd9, 16'h00AA, 1'b1, 4'd8, 1'b1, 4'd7,  4'd3,  1'b1, 16'h0000, 16'h0033, 2'b11, 1'b1, 16'h0088};
        tbl[14] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd9,  4'd8,  1'b1, 16'h00AA, 16'h0000, 2'b00, 1'b1, 16'h0000};

        #1;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iv,
                  tbl[i].ia, tbl[i].fl, tbl[i].a0, tbl[i].a1);
            #1;
            if (tbl[i].do_chk) begin
                chk($sformatf("tbl%0d.rd0", i),   rd_data[15:0],  tbl[i].e0);
                chk($sformatf("tbl%0d.rd1", i),   rd_data[31:16], tbl[i].e1);
                chk($sformatf("tbl%0d.rbusy", i), rd_busy,        tbl[i].erb);
                chk($sformatf("tbl%0d.ready", i), issue_ready,    tbl[i].erdy);
                chk($sformatf("tbl%0d.busy", i),  busy_vec,       tbl[i].ebusy);
            end
            tick();
        end

        // Bypass: one producer pending on r4, writeback while both ports read r4.
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0, 4'd4, 4'd4);
        #1; tick();
        drive(1'b0, 1'b1, 4'd4, 16'h55AA, 1'b0, 4'd0, 1'b0, 4'd4, 4'd4);
        #1;
        chk("byp.rd0",   rd_data[15:0], BYP ? 16'h55AA : 16'h0000);
        chk("byp.rbusy", rd_busy,       BYP ? 2'b00 : 2'b11);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd4, 4'd4);
        #1;
        chk("byp_next.rd0",   rd_data[15:0], 16'h55AA);
        chk("byp_next.rbusy", rd_busy,       2'b00);
        tick();

        // Writeback to an idle register commits data and leaves the count at 0.
        drive(1'b0, 1'b1, 4'd6, 16'h6666, 1'b0, 4'd0, 1'b0, 4'd1, 4'd1);
        #1; tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b0, 4'd6, 4'd2);
        #1;
        chk("idle_wr.rd6",  rd_data[15:0], 16'h6666);
        chk("idle_wr.busy", busy_vec,      16'h0000);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b0, 4'd6, 4'd2);
        #1; tick();
        drive(1'b1, 1'b1, 4'd6, 16'h7777, 1'b1, 4'd2, 1'b1, 4'd6, 4'd2);
        #1;
        chk("pre_rst.busy", busy_vec, 16'h0004);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd6, 4'd2);
        #1;
        chk("post_rst.busy",  busy_vec,       16'h0000);
        chk("post_rst.rd6",   rd_data[15:0],  16'h0000);
        chk("post_rst.rbusy", rd_busy,        2'b00);
        chk("post_rst.ready", issue_ready,    1'b1);
        tick();

        // Randomized traffic; narrow address range on issue/write to hit saturation.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  $urandom_range(0, 2) == 0,
                  4'($urandom_range(0, 5)),
                  16'($urandom),
                  $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 5)),
                  ($urandom_range(0, 24) == 0),
                  4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)));
            #1;
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
